// File: rtl/adc_scheduler_if.sv
// Requester-side bus of the ADC scheduler: level requests with per-requester
// channel/unipolar config in, one-hot grants and tagged results out.
interface adc_scheduler_if;
    logic [3:0]  REQ;
    logic [11:0] REQ_CH;
    logic [3:0]  REQ_UNI;
    logic [3:0]  GNT;
    logic        BUSY;
    logic [11:0] RESULT;
    logic [1:0]  RESULT_ID;
    logic [2:0]  RESULT_CH;
    logic        RESULT_VALID;

    // Requester side
    modport master (
        output REQ, REQ_CH, REQ_UNI,
        input  GNT, BUSY, RESULT, RESULT_ID, RESULT_CH, RESULT_VALID
    );

    // Scheduler side
    modport slave (
        input  REQ, REQ_CH, REQ_UNI,
        output GNT, BUSY, RESULT, RESULT_ID, RESULT_CH, RESULT_VALID
    );
endinterface

// File: rtl/adc_scheduler.sv
// adc_scheduler: round-robin arbiter sharing one serial ADC between four
// requesters. Each frame is CONV -> WAIT -> SHIFT -> DONE; the ADC returns the
// previous frame's conversion, so results are tagged with the prior frame's
// owner, and an idle flush frame drains the last pending result.
module adc_scheduler #(
    parameter int CLK_DIV      = 2,
    parameter int TCONV_CYCLES = 80
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    adc_scheduler_if.slave  bus,
    output logic            ADC_CONVST,
    output logic            ADC_SCK,
    output logic            ADC_SDI,
    input  logic            ADC_SDO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_e;

    state_e      state_q;
    logic [1:0]  ptr_q;
    logic        tag_valid_q;
    logic [1:0]  tag_id_q;
    logic [2:0]  tag_ch_q;
    logic [1:0]  frame_id_q;
    logic        flush_q;
    logic [2:0]  cfg_ch_q;
    logic        cfg_uni_q;
    logic [15:0] cnt_q;
    logic [8:0]  div_q;
    logic [3:0]  bit_q;
    logic [11:0] shreg_q;
    logic [3:0]  gnt_q;
    logic        busy_q;
    logic [11:0] result_q;
    logic [1:0]  result_id_q;
    logic [2:0]  result_ch_q;
    logic        result_valid_q;
    logic        convst_q;
    logic        sck_q;
    logic        sdi_q;

    logic        pick_found_d;
    logic [1:0]  pick_id_d;
    logic [1:0]  cand_d;
    logic [2:0]  pick_ch_d;
    logic        pick_uni_d;
    logic [11:0] cfg_word_d;

    // Round-robin search: first requester at or after the pointer, wrapping 3->0
    always_comb begin
        pick_found_d = 1'b0;
        pick_id_d    = '0;
        cand_d       = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand_d = ptr_q + 2'(k);
            if (!pick_found_d && bus.REQ[cand_d]) begin
                pick_found_d = 1'b1;
                pick_id_d    = cand_d;
            end
        end
    end

    // Channel and unipolar select of the chosen requester
    always_comb begin
        pick_ch_d  = '0;
        pick_uni_d = 1'b0;
        case (pick_id_d)
            2'd0: begin pick_ch_d = bus.REQ_CH[2:0];  pick_uni_d = bus.REQ_UNI[0]; end
            2'd1: begin pick_ch_d = bus.REQ_CH[5:3];  pick_uni_d = bus.REQ_UNI[1]; end
            2'd2: begin pick_ch_d = bus.REQ_CH[8:6];  pick_uni_d = bus.REQ_UNI[2]; end
            default: begin pick_ch_d = bus.REQ_CH[11:9]; pick_uni_d = bus.REQ_UNI[3]; end
        endcase
    end

    // ADC config word: single-ended, odd/sign, S1, S0, UNI, no sleep, then zeros
    always_comb begin
        cfg_word_d = {1'b1, cfg_ch_q[0], cfg_ch_q[2], cfg_ch_q[1], cfg_uni_q, 1'b0, 6'b0};
    end

    // Frame FSM with registered outputs; each output register holds the value
    // belonging to the state being entered, so outputs line up with state_q.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            tag_valid_q    <= 1'b0;
            tag_id_q       <= '0;
            tag_ch_q       <= '0;
            frame_id_q     <= '0;
            flush_q        <= 1'b0;
            cfg_ch_q       <= '0;
            cfg_uni_q      <= 1'b0;
            cnt_q          <= '0;
            div_q          <= '0;
            bit_q          <= '0;
            shreg_q        <= '0;
            gnt_q          <= '0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_id_q    <= '0;
            result_ch_q    <= '0;
            result_valid_q <= 1'b0;
            convst_q       <= 1'b0;
            sck_q          <= 1'b0;
            sdi_q          <= 1'b0;
        end else begin
            gnt_q          <= '0;
            result_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_found_d) begin
                        gnt_q      <= 4'b0001 << pick_id_d;
                        ptr_q      <= pick_id_d + 2'd1;
                        frame_id_q <= pick_id_d;
                        cfg_ch_q   <= pick_ch_d;
                        cfg_uni_q  <= pick_uni_d;
                        flush_q    <= 1'b0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        convst_q   <= 1'b1;
                        state_q    <= ST_CONV;
                    end else if (tag_valid_q) begin
                        // Flush frame: reuse the last config to collect the pending result
                        flush_q    <= 1'b1;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        convst_q   <= 1'b1;
                        state_q    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (cnt_q == 16'd1) begin
                        cnt_q    <= '0;
                        convst_q <= 1'b0;
                        state_q  <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 16'(TCONV_CYCLES - 1)) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        sck_q   <= 1'b0;
                        sdi_q   <= cfg_word_d[11];
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_SHIFT: begin
                    if (div_q == 9'(2 * CLK_DIV - 1)) begin
                        sck_q <= 1'b0;
                        if (bit_q == 4'd11) begin
                            sdi_q   <= 1'b0;
                            state_q <= ST_DONE;
                            // All 12 bits were sampled at the last rising SCK edge,
                            // so the result and tag move together on DONE entry.
                            if (tag_valid_q) begin
                                result_q       <= shreg_q;
                                result_id_q    <= tag_id_q;
                                result_ch_q    <= tag_ch_q;
                                result_valid_q <= 1'b1;
                            end
                            if (flush_q) begin
                                tag_valid_q <= 1'b0;
                            end else begin
                                tag_valid_q <= 1'b1;
                                tag_id_q    <= frame_id_q;
                                tag_ch_q    <= cfg_ch_q;
                            end
                        end else begin
                            div_q <= '0;
                            bit_q <= bit_q + 4'd1;
                            sdi_q <= cfg_word_d[4'd10 - bit_q];
                        end
                    end else begin
                        div_q <= div_q + 9'd1;
                        if (div_q == 9'(CLK_DIV - 1)) begin
                            sck_q   <= 1'b1;
                            shreg_q <= {shreg_q[10:0], ADC_SDO};
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.GNT          = gnt_q;
    assign bus.BUSY         = busy_q;
    assign bus.RESULT       = result_q;
    assign bus.RESULT_ID    = result_id_q;
    assign bus.RESULT_CH    = result_ch_q;
    assign bus.RESULT_VALID = result_valid_q;
    assign ADC_CONVST       = convst_q;
    assign ADC_SCK          = sck_q;
    assign ADC_SDI          = sdi_q;

endmodule

// File: tb/tb_adc_scheduler.sv
// Directed bench for adc_scheduler at CLK_DIV=2, TCONV_CYCLES=80 with a simple
// serial ADC model that shifts out a preset word MSB first.
module tb_adc_scheduler;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;
    logic ADC_CONVST;
    logic ADC_SCK;
    logic ADC_SDI;
    logic ADC_SDO  = 1'b0;

    adc_scheduler_if bus ();

    adc_scheduler #(.CLK_DIV(2), .TCONV_CYCLES(80)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .bus        (bus),
        .ADC_CONVST (ADC_CONVST),
        .ADC_SCK    (ADC_SCK),
        .ADC_SDI    (ADC_SDI),
        .ADC_SDO    (ADC_SDO)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    // Monitor / ADC model state
    int          cyc          = 0;
    int          sck_rises    = 0;
    int          convst_cycles = 0;
    int          gnt_count    = 0;
    int          rv_count     = 0;
    int          sdo_idx      = 12;
    logic        sck_prev     = 1'b0;
    logic [11:0] sdi_hist     = '0;
    logic [11:0] sdo_word     = '0;

    // Observe on the falling edge and drive SDO, changing it after SCK falls
    always @(negedge CLOCK_50) begin
        cyc = cyc + 1;
        if (ADC_SCK && !sck_prev) begin
            sck_rises = sck_rises + 1;
            sdi_hist  = {sdi_hist[10:0], ADC_SDI};
        end
        if (ADC_CONVST) begin
            convst_cycles = convst_cycles + 1;
            sdo_idx = 0;
        end else if (sck_prev && !ADC_SCK) begin
            sdo_idx = sdo_idx + 1;
        end
        if (|bus.GNT) gnt_count = gnt_count + 1;
        if (bus.RESULT_VALID) rv_count = rv_count + 1;
        sck_prev = ADC_SCK;
        ADC_SDO  = (sdo_idx < 12) ? sdo_word[11 - sdo_idx] : 1'b0;
    end

    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic wait_gnt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!ok) begin
                tick();
                if (|bus.GNT) ok = 1'b1;
            end
        end
    endtask

    task automatic wait_rv(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!ok) begin
                tick();
                if (bus.RESULT_VALID) ok = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!ok) begin
                tick();
                if (!bus.BUSY) ok = 1'b1;
            end
        end
    endtask

    task automatic wait_sck(input int base, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!ok) begin
                tick();
                if (sck_rises - base >= n) ok = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        RESET       = 1'b1;
        bus.REQ     = '0;
        bus.REQ_CH  = '0;
        bus.REQ_UNI = '0;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RESET       = 1'b1;
        bus.REQ     = 4'b1111;
        bus.REQ_CH  = '0;
        bus.REQ_UNI = '0;
        repeat (3) tick();
        total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", bus.GNT); end
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.BUSY); end
        total++; if (bus.RESULT_VALID !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b want=0", bus.RESULT_VALID); end
        total++; if (bus.RESULT !== 12'h000) begin bad++; $display("FAIL reset_result got=%h want=000", bus.RESULT); end
        total++; if (bus.RESULT_ID !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", bus.RESULT_ID); end
        total++; if (bus.RESULT_CH !== 3'd0) begin bad++; $display("FAIL reset_ch got=%0d want=0", bus.RESULT_CH); end
        total++; if (ADC_CONVST !== 1'b0) begin bad++; $display("FAIL reset_convst got=%b want=0", ADC_CONVST); end
        total++; if (ADC_SCK !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", ADC_SCK); end
        total++; if (ADC_SDI !== 1'b0) begin bad++; $display("FAIL reset_sdi got=%b want=0", ADC_SDI); end
        bus.REQ = '0;
        RESET   = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        int t0, c0, s0, r0, g0;
        do_reset();
        sdo_word = 12'hA5C;
        c0 = convst_cycles; s0 = sck_rises; r0 = rv_count; g0 = gnt_count;
        bus.REQ_CH  = 12'h005;
        bus.REQ_UNI = 4'b0001;
        bus.REQ     = 4'b0001;
        wait_gnt(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_gnt_seen got=timeout want=grant"); end
        total++; if (bus.GNT !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", bus.GNT); end
        t0 = cyc;
        bus.REQ = '0;
        tick();
        total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL single_gnt_pulse got=%b want=0000", bus.GNT); end
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_idle got=timeout want=idle"); end
        total++; if (cyc - t0 !== 131) begin bad++; $display("FAIL single_busy_len got=%0d want=131", cyc - t0); end
        total++; if (convst_cycles - c0 !== 2) begin bad++; $display("FAIL single_convst got=%0d want=2", convst_cycles - c0); end
        total++; if (sck_rises - s0 !== 12) begin bad++; $display("FAIL single_sck got=%0d want=12", sck_rises - s0); end
        total++; if (sdi_hist !== 12'hE80) begin bad++; $display("FAIL single_sdi got=%h want=e80", sdi_hist); end
        total++; if (rv_count - r0 !== 0) begin bad++; $display("FAIL single_no_rv got=%0d want=0", rv_count - r0); end
        // The flush frame follows on its own and delivers the result
        wait_rv(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL flush_rv_seen got=timeout want=valid"); end
        total++; if (cyc - t0 !== 262) begin bad++; $display("FAIL flush_rv_time got=%0d want=262", cyc - t0); end
        total++; if (bus.RESULT !== 12'hA5C) begin bad++; $display("FAIL flush_result got=%h want=a5c", bus.RESULT); end
        total++; if (bus.RESULT_ID !== 2'd0) begin bad++; $display("FAIL flush_id got=%0d want=0", bus.RESULT_ID); end
        total++; if (bus.RESULT_CH !== 3'd5) begin bad++; $display("FAIL flush_ch got=%0d want=5", bus.RESULT_CH); end
        total++; if (gnt_count - g0 !== 1) begin bad++; $display("FAIL flush_no_gnt got=%0d want=1", gnt_count - g0); end
        tick();
        total++; if (bus.RESULT_VALID !== 1'b0) begin bad++; $display("FAIL flush_rv_pulse got=%b want=0", bus.RESULT_VALID); end
        total++; if (bus.RESULT !== 12'hA5C) begin bad++; $display("FAIL flush_result_hold got=%h want=a5c", bus.RESULT); end
        repeat (6) tick();
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL flush_then_idle got=%b want=0", bus.BUSY); end
    endtask

    localparam logic [11:0] RR_WORD [5] = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF};
    localparam logic [3:0]  RR_GNT  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [1:0]  RR_ID   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    localparam logic [2:0]  RR_CH   [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd2};
    localparam logic [11:0] RR_SDI  [5] = '{12'h900, 12'hD00, 12'hA00, 12'hE00, 12'h900};

    task automatic test_round_robin();
        bit ok;
        int prev;
        do_reset();
        prev = 0;
        bus.REQ_CH  = {3'd5, 3'd4, 3'd3, 3'd2};
        bus.REQ_UNI = 4'b0000;
        bus.REQ     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(300, ok);
            total++; if (!ok) begin bad++; $display("FAIL rr_gnt_seen[%0d] got=timeout want=grant", k); end
            total++; if (bus.GNT !== RR_GNT[k]) begin bad++; $display("FAIL rr_gnt[%0d] got=%b want=%b", k, bus.GNT, RR_GNT[k]); end
            if (k > 0) begin
                total++; if (cyc - prev !== 132) begin bad++; $display("FAIL rr_spacing[%0d] got=%0d want=132", k, cyc - prev); end
            end
            prev = cyc;
            sdo_word = RR_WORD[k];
            if (k > 0) begin
                wait_rv(200, ok);
                total++; if (!ok) begin bad++; $display("FAIL rr_rv_seen[%0d] got=timeout want=valid", k); end
                total++; if (bus.RESULT !== RR_WORD[k]) begin bad++; $display("FAIL rr_result[%0d] got=%h want=%h", k, bus.RESULT, RR_WORD[k]); end
                total++; if (bus.RESULT_ID !== RR_ID[k-1]) begin bad++; $display("FAIL rr_id[%0d] got=%0d want=%0d", k, bus.RESULT_ID, RR_ID[k-1]); end
                total++; if (bus.RESULT_CH !== RR_CH[k-1]) begin bad++; $display("FAIL rr_ch[%0d] got=%0d want=%0d", k, bus.RESULT_CH, RR_CH[k-1]); end
                total++; if (sdi_hist !== RR_SDI[k]) begin bad++; $display("FAIL rr_sdi[%0d] got=%h want=%h", k, sdi_hist, RR_SDI[k]); end
            end
        end
        bus.REQ = '0;
    endtask

    task automatic test_pointer_wrap();
        bit ok;
        int t0;
        do_reset();
        bus.REQ_CH = {3'd7, 3'd6, 3'd5, 3'd4};
        bus.REQ    = 4'b0100;
        wait_gnt(10, ok);
        total++; if (bus.GNT !== 4'b0100 || !ok) begin bad++; $display("FAIL wrap_first got=%b want=0100", bus.GNT); end
        t0 = cyc;
        bus.REQ = 4'b0101;
        wait_gnt(300, ok);
        total++; if (bus.GNT !== 4'b0001 || !ok) begin bad++; $display("FAIL wrap_grant0 got=%b want=0001", bus.GNT); end
        total++; if (cyc - t0 !== 132) begin bad++; $display("FAIL wrap_spacing got=%0d want=132", cyc - t0); end
        wait_gnt(300, ok);
        total++; if (bus.GNT !== 4'b0100 || !ok) begin bad++; $display("FAIL wrap_ptr1 got=%b want=0100", bus.GNT); end
        bus.REQ = '0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int t0, s0, r0;
        do_reset();
        sdo_word    = 12'h3C6;
        bus.REQ_CH  = {3'd0, 3'd0, 3'd1, 3'd3};
        bus.REQ_UNI = 4'b0000;
        bus.REQ     = 4'b0001;
        wait_gnt(10, ok);
        total++; if (bus.GNT !== 4'b0001 || !ok) begin bad++; $display("FAIL b2b_first got=%b want=0001", bus.GNT); end
        t0 = cyc; s0 = sck_rises; r0 = rv_count;
        bus.REQ = '0;
        wait_sck(s0, 12, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_sck got=timeout want=12 edges"); end
        bus.REQ = 4'b0010;
        wait_gnt(50, ok);
        total++; if (bus.GNT !== 4'b0010 || !ok) begin bad++; $display("FAIL b2b_second got=%b want=0010", bus.GNT); end
        total++; if (cyc - t0 !== 132) begin bad++; $display("FAIL b2b_spacing got=%0d want=132", cyc - t0); end
        total++; if (rv_count - r0 !== 0) begin bad++; $display("FAIL b2b_no_flush got=%0d want=0", rv_count - r0); end
        bus.REQ = '0;
        wait_rv(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_rv got=timeout want=valid"); end
        total++; if (cyc - t0 !== 262) begin bad++; $display("FAIL b2b_rv_time got=%0d want=262", cyc - t0); end
        total++; if (bus.RESULT_ID !== 2'd0 || bus.RESULT_CH !== 3'd3) begin bad++; $display("FAIL b2b_tag got=%0d/%0d want=0/3", bus.RESULT_ID, bus.RESULT_CH); end
        total++; if (bus.RESULT !== 12'h3C6) begin bad++; $display("FAIL b2b_result got=%h want=3c6", bus.RESULT); end
    endtask

    task automatic test_req_during_wait();
        bit ok;
        int t0, drops, early;
        do_reset();
        bus.REQ = 4'b0001;
        wait_gnt(10, ok);
        total++; if (bus.GNT !== 4'b0001 || !ok) begin bad++; $display("FAIL wait_first got=%b want=0001", bus.GNT); end
        t0 = cyc;
        bus.REQ = '0;
        drops = 0;
        early = 0;
        for (int i = 1; i <= 130; i++) begin
            tick();
            if (i == 10) bus.REQ = 4'b0010;
            if (bus.BUSY !== 1'b1) drops++;
            if (bus.GNT !== 4'b0000) early++;
        end
        total++; if (drops !== 0) begin bad++; $display("FAIL wait_busy_drops got=%0d want=0", drops); end
        total++; if (early !== 0) begin bad++; $display("FAIL wait_early_gnt got=%0d want=0", early); end
        tick();
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL wait_idle_gap got=%b want=0", bus.BUSY); end
        tick();
        total++; if (bus.GNT !== 4'b0010) begin bad++; $display("FAIL wait_late_gnt got=%b want=0010", bus.GNT); end
        bus.REQ = '0;
    endtask

    task automatic test_reset_in_shift();
        bit ok;
        int s0, r0;
        do_reset();
        bus.REQ = 4'b0001;
        wait_gnt(10, ok);
        total++; if (bus.GNT !== 4'b0001 || !ok) begin bad++; $display("FAIL rst_first got=%b want=0001", bus.GNT); end
        s0 = sck_rises;
        bus.REQ = '0;
        wait_sck(s0, 6, 200, ok);
        total++; if (!ok || ADC_SCK !== 1'b1) begin bad++; $display("FAIL rst_period5 got=%b want=1", ADC_SCK); end
        r0 = rv_count;
        RESET = 1'b1;
        tick();
        total++; if (ADC_SCK !== 1'b0) begin bad++; $display("FAIL rst_sck got=%b want=0", ADC_SCK); end
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.BUSY); end
        total++; if (bus.RESULT_VALID !== 1'b0) begin bad++; $display("FAIL rst_rv got=%b want=0", bus.RESULT_VALID); end
        RESET = 1'b0;
        repeat (8) tick();
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rst_no_flush got=%b want=0", bus.BUSY); end
        bus.REQ = 4'b0011;
        wait_gnt(10, ok);
        total++; if (bus.GNT !== 4'b0001 || !ok) begin bad++; $display("FAIL rst_ptr got=%b want=0001", bus.GNT); end
        bus.REQ = '0;
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_frame_end got=timeout want=idle"); end
        total++; if (rv_count - r0 !== 0) begin bad++; $display("FAIL rst_no_rv got=%0d want=0", rv_count - r0); end
    endtask

    initial begin
        bus.REQ     = '0;
        bus.REQ_CH  = '0;
        bus.REQ_UNI = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_back_to_back();
        test_req_during_wait();
        test_reset_in_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_scheduler.md
ADC_SCHEDULER -- requirements
Module: adc_scheduler

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, giving the ADC_SCK half-period in CLOCK_50 cycles (legal range 1..255).
REQ-002 The block SHALL have parameter TCONV_CYCLES, default 80, giving the conversion wait in CLOCK_50 cycles (1.6 us at 50 MHz).
REQ-003 The block SHALL have these ports:
  CLOCK_50  in  1  sole clock, all logic on rising edge.
  RESET  in  1  synchronous, active-high reset.
  REQ  in  4  level conversion request, one bit per requester 0..3.
  REQ_CH  in  12  channel per requester; requester i uses bits [3i+2:3i].
  REQ_UNI  in  4  per-requester unipolar select.
  GNT  out  4  one-hot, one-cycle grant pulse.
  BUSY  out  1  high whenever the FSM is not IDLE.
  RESULT  out  12  conversion data, MSB first off ADC_SDO.
  RESULT_ID  out  2  requester that owns RESULT.
  RESULT_CH  out  3  channel that owns RESULT.
  RESULT_VALID  out  1  one-cycle strobe qualifying RESULT, RESULT_ID and RESULT_CH.
  ADC_CONVST  out  1  ADC conversion start.
  ADC_SCK  out  1  ADC serial clock.
  ADC_SDI  out  1  ADC config bit.
  ADC_SDO  in  1  ADC data bit.
REQ-004 Clock and reset SHALL be as decided: one clock; reset is synchronous and active-high.

Function
REQ-005 FSM states SHALL be IDLE, CONV, WAIT, SHIFT and DONE.
REQ-006 IDLE SHALL behave as follows:
  - If any REQ bit is high, grant the first requester at or after the round-robin pointer (wrapping 3->0).
  - On that cycle, pulse its GNT bit, latch its channel and UNI into the frame config, and go to CONV.
  - Set the pointer to (granted id + 1) mod 4.
  - Requests are only granted in IDLE; a requester deasserts REQ after seeing GNT.
REQ-007 IDLE flush: if REQ is all zero and the previous-frame tag is valid, IDLE SHALL start a flush frame. The flush frame uses the last config, pulses no GNT bit and leaves the pointer unchanged.
REQ-008 CONV SHALL drive ADC_CONVST high for exactly 2 cycles, then go to WAIT.
REQ-009 WAIT SHALL count TCONV_CYCLES cycles with ADC_CONVST low, then go to SHIFT.
REQ-010 SHIFT SHALL generate 12 ADC_SCK periods of 2*CLK_DIV cycles each:
  - ADC_SCK is low for the first half-period and high for the second.
  - ADC_SCK is low in every other state.
REQ-011 ADC_SDI SHALL present config word bit k (MSB first) for the whole of SCK period k. The word is {1, ch[0], ch[2], ch[1], UNI, 0}, i.e. single-ended, odd/sign, S1, S0, UNI, no sleep. Periods 6..11 drive 0. ADC_SDI is 0 outside SHIFT.
REQ-012 SHIFT SHALL sample ADC_SDO on the CLOCK_50 edge where ADC_SCK goes 0->1 and shift it into a 12-bit register MSB first.
REQ-013 After the 12th period SHIFT SHALL go to DONE.
REQ-014 The ADC returns the previous frame's conversion. The block SHALL keep a tag {valid, id, ch} of the prior frame; the tag is invalid after reset.
REQ-015 DONE SHALL last one cycle and then return to IDLE:
  - If the tag is valid, drive RESULT, RESULT_ID = tag id, RESULT_CH = tag ch, and pulse RESULT_VALID.
  - Then load the tag with the current frame's {1, id, ch} for a granted frame, or {0, x, x} for a flush frame.
REQ-016 RESULT, RESULT_ID and RESULT_CH SHALL hold their value until the next RESULT_VALID.
REQ-017 Frame length from GNT to DONE (inclusive) SHALL be 1 + 2 + TCONV_CYCLES + 24*CLK_DIV + 1 cycles, i.e. 132 cycles at default parameters.
REQ-018 REQ changes outside IDLE SHALL be ignored. Simultaneous requests SHALL be resolved only by the pointer, with no fixed priority.

Reset
REQ-019 While RESET is high at a clock edge, the block SHALL set:
  - state IDLE and pointer 0;
  - tag invalid;
  - GNT=0, BUSY=0, RESULT_VALID=0;
  - RESULT=0, RESULT_ID=0, RESULT_CH=0;
  - ADC_CONVST=0, ADC_SCK=0, ADC_SDI=0.
REQ-020 RESET asserted mid-frame (any state) SHALL abort the frame on the next edge with no RESULT_VALID and no GNT. The first frame after reset SHALL produce no RESULT_VALID.

Verification
REQ-021 Bench scenarios (CLK_DIV=2, TCONV_CYCLES=80):
  - Single request: REQ=0001, REQ_CH[2:0]=5, UNI=1 -> GNT=0001 for 1 cycle; ADC_CONVST high 2 cycles; SDI bits 1,1,1,0,1,0; 12 SCK rising edges; no RESULT_VALID. Then a flush frame follows with RESULT_VALID, RESULT_ID=0, RESULT_CH=5, RESULT equal to the SDO model word (e.g. 12'hA5C).
  - All four requesting, REQ=1111 held: grants 0,1,2,3,0 in order, 132 cycles apart; each result is tagged with the previous grant's id and channel.
  - Pointer wrap: pointer=3, REQ=0101 -> grant requester 0, pointer becomes 1.
  - Back-to-back: new REQ present in the cycle DONE returns to IDLE -> GNT the next cycle, no flush frame inserted.
  - Reset during SHIFT period 5 -> next cycle ADC_SCK=0, BUSY=0, no RESULT_VALID; the following frame produces no RESULT_VALID.
  - Request arriving during WAIT: it is not granted until IDLE and BUSY stays high throughout the frame.
